// File: rtl/demux16_pkg.sv
// Shared constants and types for the demux16_stream block: default widths,
// channel select encodings and the per-channel slot state.
package demux16_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux16_pkg

// File: rtl/demux16_if.sv
// Handshake bundle for demux16_stream: one producer input and two consumer
// channels, each with its transfer counter.
interface demux16_if
  import demux16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  // Producer and consumers drive this side.
  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

  // The demultiplexer itself.
  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

endinterface : demux16_if

// File: rtl/demux16_slot.sv
// One-entry output register with valid/ready on both sides and a wrapping
// count of words handed to the consumer.
module demux16_slot
  import demux16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count
);

  slot_state_e      r_state;
  slot_state_e      w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Accept while empty, or while the held word leaves on this same edge.
  assign w_out_xfer = (r_state == SLOT_FULL) && i_ready;
  assign o_ready    = (r_state == SLOT_EMPTY) || i_ready;
  assign w_in_xfer  = i_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: the hold value is assigned first so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      SLOT_EMPTY: if (w_in_xfer) w_state_next = SLOT_FULL;
      SLOT_FULL:  if (w_out_xfer && !w_in_xfer) w_state_next = SLOT_EMPTY;
      default:    w_state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset too, so a_data/b_data read 0 out of reset.
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
    end else begin
      if (w_in_xfer)  r_data  <= i_data;
      if (w_out_xfer) r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == SLOT_FULL);
  assign o_count = r_count;

endmodule : demux16_slot

// File: rtl/demux16_stream.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to channel A or B
// by in_sel; each channel buffers one word in its own slot.
module demux16_stream
  import demux16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  demux16_if.slave   bus
);

  logic w_sel_a;
  logic w_a_in_valid;
  logic w_b_in_valid;
  logic w_a_in_ready;
  logic w_b_in_ready;

  assign w_sel_a      = (bus.in_sel == SEL_A);
  assign w_a_in_valid = bus.in_valid && w_sel_a;
  assign w_b_in_valid = bus.in_valid && !w_sel_a;

  // Only the selected channel's readiness is visible to the producer.
  assign bus.in_ready = w_sel_a ? w_a_in_ready : w_b_in_ready;

  demux16_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (bus.in_data),
    .i_valid (w_a_in_valid),
    .o_ready (w_a_in_ready),
    .o_data  (bus.a_data),
    .o_valid (bus.a_valid),
    .i_ready (bus.a_ready),
    .o_count (bus.a_count)
  );

  demux16_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (bus.in_data),
    .i_valid (w_b_in_valid),
    .o_ready (w_b_in_ready),
    .o_data  (bus.b_data),
    .o_valid (bus.b_valid),
    .i_ready (bus.b_ready),
    .o_count (bus.b_count)
  );

endmodule : demux16_stream

// File: tb/tb_demux16_stream.sv
// Directed self-checking bench for demux16_stream, with background monitors
// for the producer and consumer stability rules.
module tb_demux16_stream;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  demux16_if #(.WIDTH(16), .CNT_W(16)) bus ();

  demux16_stream #(.WIDTH(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stability monitors, sampled on the falling edge.
  logic        p_rst, p_in_valid, p_in_ready, p_in_sel;
  logic [15:0] p_in_data;
  logic        p_a_valid, p_a_ready, p_b_valid, p_b_ready;
  logic [15:0] p_a_data, p_b_data;
  bit          p_seen = 0;

  always @(negedge clk) begin
    if (p_seen && p_rst && rst_n) begin
      if (p_in_valid && !p_in_ready) begin
        n_checks++;
        if (!bus.in_valid || bus.in_data !== p_in_data || bus.in_sel !== p_in_sel) begin
          n_fail++;
          $display("FAIL producer_hold: valid=%b data=%h sel=%b, required valid=1 data=%h sel=%b",
                   bus.in_valid, bus.in_data, bus.in_sel, p_in_data, p_in_sel);
        end
      end
      if (p_a_valid && !p_a_ready) begin
        n_checks++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== p_a_data) begin
          n_fail++;
          $display("FAIL a_hold: valid=%b data=%h, required valid=1 data=%h",
                   bus.a_valid, bus.a_data, p_a_data);
        end
      end
      if (p_b_valid && !p_b_ready) begin
        n_checks++;
        if (bus.b_valid !== 1'b1 || bus.b_data !== p_b_data) begin
          n_fail++;
          $display("FAIL b_hold: valid=%b data=%h, required valid=1 data=%h",
                   bus.b_valid, bus.b_data, p_b_data);
        end
      end
    end
    p_seen     = 1;
    p_rst      = rst_n;
    p_in_valid = bus.in_valid;
    p_in_ready = bus.in_ready;
    p_in_sel   = bus.in_sel;
    p_in_data  = bus.in_data;
    p_a_valid  = bus.a_valid;
    p_a_ready  = bus.a_ready;
    p_a_data   = bus.a_data;
    p_b_valid  = bus.b_valid;
    p_b_ready  = bus.b_ready;
    p_b_data   = bus.b_data;
  end

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_data  = 16'h0000;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.a_valid, bus.b_valid} !== 2'b00 || bus.a_data !== 16'h0 || bus.b_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_slots: a_valid=%b b_valid=%b a_data=%h b_data=%h, required 0 0 0000 0000",
               bus.a_valid, bus.b_valid, bus.a_data, bus.b_data);
    end
    n_checks++;
    if (bus.a_count !== 16'h0 || bus.b_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_counts: a_count=%h b_count=%h, required 0000 0000", bus.a_count, bus.b_count);
    end
    for (int s = 0; s < 2; s++) begin
      bus.in_sel = s[0];
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready sel=%0d: in_ready=%b, required 1", s, bus.in_ready);
      end
    end
    bus.in_sel = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    bus.in_data  = 16'hAAAA;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 16'hAAAA || bus.a_count !== 16'd0 || bus.b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_a_held: a_valid=%b a_data=%h a_count=%0d b_valid=%b, required 1 AAAA 0 0",
               bus.a_valid, bus.a_data, bus.a_count, bus.b_valid);
    end
    tick();
    n_checks++;
    if (bus.a_valid !== 1'b0 || bus.a_count !== 16'd1 || bus.b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_a_taken: a_valid=%b a_count=%0d b_valid=%b, required 0 1 0",
               bus.a_valid, bus.a_count, bus.b_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4] = '{16'h0101, 16'h0102, 16'h0103, 16'h0104};
    bus.in_data  = 16'h1234;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 16'h5678;
    bus.in_sel  = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.b_valid !== 1'b1 || bus.b_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL b2b_first: in_ready=%b b_valid=%b b_data=%h, required 1 1 1234",
               bus.in_ready, bus.b_valid, bus.b_data);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.b_valid !== 1'b0 || bus.b_count !== 16'd1 || bus.a_valid !== 1'b1 || bus.a_data !== 16'h5678) begin
      n_fail++;
      $display("FAIL b2b_second: b_valid=%b b_count=%0d a_valid=%b a_data=%h, required 0 1 1 5678",
               bus.b_valid, bus.b_count, bus.a_valid, bus.a_data);
    end
    tick();
    n_checks++;
    if (bus.a_valid !== 1'b0 || bus.a_count !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_a_taken: a_valid=%b a_count=%0d, required 0 2", bus.a_valid, bus.a_count);
    end
    // One word per cycle into A with the consumer always ready.
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = words[i];
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_in_ready[%0d]: in_ready=%b, required 1", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== words[i]) begin
        n_fail++;
        $display("FAIL stream_a[%0d]: a_valid=%b a_data=%h, required 1 %h", i, bus.a_valid, bus.a_data, words[i]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.a_valid !== 1'b0 || bus.a_count !== 16'd6) begin
      n_fail++;
      $display("FAIL stream_done: a_valid=%b a_count=%0d, required 0 6", bus.a_valid, bus.a_count);
    end
  endtask

  task automatic test_stall_a();
    bus.a_ready  = 1'b0;
    bus.in_data  = 16'h0001;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 16'h0002;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.a_valid !== 1'b1 || bus.a_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL stall_first: in_ready=%b a_valid=%b a_data=%h, required 0 1 0001",
               bus.in_ready, bus.a_valid, bus.a_data);
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.a_data !== 16'h0001 || bus.a_count !== 16'd6) begin
      n_fail++;
      $display("FAIL stall_hold: in_ready=%b a_data=%h a_count=%0d, required 0 0001 6",
               bus.in_ready, bus.a_data, bus.a_count);
    end
    bus.a_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 16'h0002 || bus.a_count !== 16'd7) begin
      n_fail++;
      $display("FAIL stall_second: a_valid=%b a_data=%h a_count=%0d, required 1 0002 7",
               bus.a_valid, bus.a_data, bus.a_count);
    end
    tick();
    n_checks++;
    if (bus.a_valid !== 1'b0 || bus.a_count !== 16'd8) begin
      n_fail++;
      $display("FAIL stall_drained: a_valid=%b a_count=%0d, required 0 8", bus.a_valid, bus.a_count);
    end
  endtask

  task automatic test_independent();
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b1;
    bus.in_data  = 16'hDEAD;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 16'hBEEF;
    bus.in_sel  = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL indep_b_ready: in_ready=%b, required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.b_valid !== 1'b1 || bus.b_data !== 16'hBEEF || bus.a_valid !== 1'b1 || bus.a_data !== 16'hDEAD) begin
      n_fail++;
      $display("FAIL indep_held: b_valid=%b b_data=%h a_valid=%b a_data=%h, required 1 BEEF 1 DEAD",
               bus.b_valid, bus.b_data, bus.a_valid, bus.a_data);
    end
    tick();
    n_checks++;
    if (bus.b_valid !== 1'b0 || bus.b_count !== 16'd2 || bus.a_data !== 16'hDEAD || bus.a_count !== 16'd8) begin
      n_fail++;
      $display("FAIL indep_b_taken: b_valid=%b b_count=%0d a_data=%h a_count=%0d, required 0 2 DEAD 8",
               bus.b_valid, bus.b_count, bus.a_data, bus.a_count);
    end
    // in_ready follows the selected channel only.
    bus.b_ready = 1'b0;
    bus.in_sel  = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL indep_sel_a: in_ready=%b, required 0", bus.in_ready);
    end
    bus.in_sel = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL indep_sel_b: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.in_data  = 16'hCAFE;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_prefill: a_valid=%b b_valid=%b, required 1 1", bus.a_valid, bus.b_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.a_valid, bus.b_valid} !== 2'b00 || bus.a_count !== 16'd0 || bus.b_count !== 16'd0
        || bus.a_data !== 16'h0 || bus.b_data !== 16'h0) begin
      n_fail++;
      $display("FAIL areset_immediate: a_valid=%b b_valid=%b a_count=%0d b_count=%0d a_data=%h b_data=%h, required all 0",
               bus.a_valid, bus.b_valid, bus.a_count, bus.b_count, bus.a_data, bus.b_data);
    end
    bus.in_data  = 16'h7777;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    n_checks++;
    if (bus.a_valid !== 1'b0 || bus.a_data !== 16'h0) begin
      n_fail++;
      $display("FAIL areset_no_xfer: a_valid=%b a_data=%h, required 0 0000", bus.a_valid, bus.a_data);
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    bus.b_ready  = 1'b1;
    bus.a_ready  = 1'b0;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      bus.in_data = i[15:0];
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.b_count !== 16'hFFFF || bus.b_valid !== 1'b1 || bus.b_data !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_before: b_count=%h b_valid=%b b_data=%h, required FFFF 1 FFFF",
               bus.b_count, bus.b_valid, bus.b_data);
    end
    tick();
    n_checks++;
    if (bus.b_count !== 16'h0000 || bus.b_valid !== 1'b0 || bus.a_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_after: b_count=%h b_valid=%b a_count=%h, required 0000 0 0000",
               bus.b_count, bus.b_valid, bus.a_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_back_to_back();
    test_stall_a();
    test_independent();
    test_async_reset();
    test_wrap();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux16_stream
